// File: rtl/pir_frontend.sv
// rtl/pir_frontend.sv - three-channel PIR debounce/hold front end with warm-up sequencing.
// Optional motion event counter enabled by PIR_EVENT_COUNT_EN.
module pir_frontend #(
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int HOLD_CYCLES     = 50,
   parameter int WARMUP_CYCLES   = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       turn,
   input  logic [2:0] raw_pir,
   output logic       pir_sensor_1,
   output logic       pir_sensor_2,
   output logic       pir_sensor_3,
   output logic       ready
`ifdef PIR_EVENT_COUNT_EN
   ,
   output logic [7:0] event_count
`endif
);

   typedef enum logic [1:0] {G_OFF, G_WARMUP, G_RUN} g_state_e;
   typedef enum logic [1:0] {CH_IDLE, CH_QUAL, CH_ACTIVE, CH_HOLD} ch_state_e;

   localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES - 1);
   localparam logic [7:0]  DEB_CNT   = 8'(DEBOUNCE_CYCLES);
   localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

   logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d;
   g_state_e    g_state_q, g_state_d;
   logic [15:0] warm_cnt_q, warm_cnt_d;
   logic        ready_q, ready_d;
   ch_state_e   ch_state_q [3];
   ch_state_e   ch_state_d [3];
   logic [7:0]  ch_cnt_q [3];
   logic [7:0]  ch_cnt_d [3];
   logic [2:0]  ch_out_q, ch_out_d;
   logic        live;

   always_comb begin
      sync1_d    = raw_pir;
      sync2_d    = sync1_q;
      g_state_d  = g_state_q;
      warm_cnt_d = warm_cnt_q;
      if (!turn) begin
         g_state_d  = G_OFF;
         warm_cnt_d = '0;
      end else begin
         case (g_state_q)
            G_OFF: begin
               g_state_d  = G_WARMUP;
               warm_cnt_d = '0;
            end
            G_WARMUP: begin
               if (warm_cnt_q == WARM_LAST) g_state_d = G_RUN;
               else warm_cnt_d = warm_cnt_q + 16'd1;
            end
            default: ;
         endcase
      end
      ready_d = (g_state_d == G_RUN);
   end

   // Channels only evolve while the previous state is RUN and turn is still high.
   always_comb begin
      live     = turn && (g_state_q == G_RUN);
      ch_out_d = ch_out_q;
      for (int i = 0; i < 3; i++) begin
         ch_state_d[i] = ch_state_q[i];
         ch_cnt_d[i]   = ch_cnt_q[i];
         if (!live) begin
            ch_state_d[i] = CH_IDLE;
            ch_cnt_d[i]   = '0;
            ch_out_d[i]   = 1'b0;
         end else begin
            case (ch_state_q[i])
               CH_IDLE: begin
                  if (sync2_q[i]) begin
                     ch_state_d[i] = CH_QUAL;
                     ch_cnt_d[i]   = 8'd1;
                  end
               end
               CH_QUAL: begin
                  if (!sync2_q[i]) begin
                     ch_state_d[i] = CH_IDLE;
                     ch_cnt_d[i]   = '0;
                  end else if (ch_cnt_q[i] >= DEB_CNT) begin
                     ch_state_d[i] = CH_ACTIVE;
                     ch_out_d[i]   = 1'b1;
                  end else begin
                     ch_cnt_d[i] = ch_cnt_q[i] + 8'd1;
                  end
               end
               CH_ACTIVE: begin
                  if (!sync2_q[i]) begin
                     ch_state_d[i] = CH_HOLD;
                     ch_cnt_d[i]   = '0;
                  end
               end
               default: begin
                  if (sync2_q[i]) begin
                     ch_state_d[i] = CH_ACTIVE;
                  end else if (ch_cnt_q[i] == HOLD_LAST) begin
                     ch_state_d[i] = CH_IDLE;
                     ch_cnt_d[i]   = '0;
                     ch_out_d[i]   = 1'b0;
                  end else begin
                     ch_cnt_d[i] = ch_cnt_q[i] + 8'd1;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         g_state_q  <= G_OFF;
         warm_cnt_q <= '0;
         ready_q    <= 1'b0;
         ch_out_q   <= '0;
         for (int i = 0; i < 3; i++) begin
            ch_state_q[i] <= CH_IDLE;
            ch_cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         g_state_q  <= g_state_d;
         warm_cnt_q <= warm_cnt_d;
         ready_q    <= ready_d;
         ch_out_q   <= ch_out_d;
         for (int i = 0; i < 3; i++) begin
            ch_state_q[i] <= ch_state_d[i];
            ch_cnt_q[i]   <= ch_cnt_d[i];
         end
      end
   end

   assign pir_sensor_1 = ch_out_q[0];
   assign pir_sensor_2 = ch_out_q[1];
   assign pir_sensor_3 = ch_out_q[2];
   assign ready        = ready_q;

`ifdef PIR_EVENT_COUNT_EN
   logic [7:0] ev_q, ev_d;
   logic [2:0] rise;
   logic [8:0] ev_sum;

   always_comb begin
      rise   = ch_out_d & ~ch_out_q;
      ev_sum = {1'b0, ev_q} + 9'(rise[0]) + 9'(rise[1]) + 9'(rise[2]);
      if (!turn || (g_state_q == G_OFF)) ev_d = '0;
      else if (ev_sum > 9'd255)          ev_d = 8'hFF;
      else                               ev_d = ev_sum[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ev_q <= '0;
      else        ev_q <= ev_d;
   end

   assign event_count = ev_q;
`endif

endmodule

// File: tb/tb_pir_frontend.sv
// tb/tb_pir_frontend.sv - randomized and directed bench for pir_frontend against a run-length model.
// Event counter checks are active when PIR_EVENT_COUNT_EN is defined.
module tb_pir_frontend;
   localparam int D = 8;
   localparam int H = 50;
   localparam int W = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       turn = 1'b0;
   logic [2:0] raw_pir = 3'b000;
   logic       pir_sensor_1, pir_sensor_2, pir_sensor_3, ready;
`ifdef PIR_EVENT_COUNT_EN
   logic [7:0] event_count;
`endif

   always #5 clk = ~clk;

   pir_frontend dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .turn         (turn),
      .raw_pir      (raw_pir),
      .pir_sensor_1 (pir_sensor_1),
      .pir_sensor_2 (pir_sensor_2),
      .pir_sensor_3 (pir_sensor_3),
      .ready        (ready)
`ifdef PIR_EVENT_COUNT_EN
      ,
      .event_count  (event_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model: sync delay line, edges since arming, and per-channel run lengths of high/low samples.
   int         m_arm = -1;
   bit         m_ready = 1'b0;
   bit [2:0]   m_out = 3'b000;
   int         m_hi [3];
   int         m_lo [3];
   logic [2:0] m_h0 = 3'b000;
   logic [2:0] m_h1 = 3'b000;
   int         m_ev = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_arm = -1; m_ready = 0; m_out = 0; m_h0 = 0; m_h1 = 0; m_ev = 0;
      for (int i = 0; i < 3; i++) begin m_hi[i] = 0; m_lo[i] = 0; end
   endtask

   task automatic model_step();
      logic [2:0] s;
      bit         live;
      int         rises;
      s     = m_h1;
      m_h1  = m_h0;
      m_h0  = raw_pir;
      live  = turn && m_ready;
      rises = 0;
      for (int i = 0; i < 3; i++) begin
         if (!live) begin
            m_out[i] = 0; m_hi[i] = 0; m_lo[i] = 0;
         end else if (!m_out[i]) begin
            m_hi[i] = s[i] ? m_hi[i] + 1 : 0;
            if (m_hi[i] == D + 1) begin m_out[i] = 1; m_lo[i] = 0; rises++; end
         end else begin
            m_lo[i] = s[i] ? 0 : m_lo[i] + 1;
            if (m_lo[i] == H + 1) begin m_out[i] = 0; m_hi[i] = 0; end
         end
      end
      if (!turn || m_arm < 0) m_ev = 0;
      else m_ev = (m_ev + rises > 255) ? 255 : m_ev + rises;
      m_arm   = turn ? m_arm + 1 : -1;
      m_ready = (m_arm >= W);
   endtask

   initial begin : model_and_monitor
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) model_reset();
         else model_step();
         @(negedge clk);
         if (rst_n) begin
            chk_eq("pir1", pir_sensor_1, m_out[0]);
            chk_eq("pir2", pir_sensor_2, m_out[1]);
            chk_eq("pir3", pir_sensor_3, m_out[2]);
            chk_eq("ready", ready, m_ready);
`ifdef PIR_EVENT_COUNT_EN
            chk_eq("event_count", event_count, m_ev);
`endif
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic arm_and_wait(output int lat);
      int t0;
      turn = 1'b1;
      t0   = cyc + 1;
      lat  = -1;
      for (int k = 0; k < 400 && lat < 0; k++) begin
         step(1);
         if (ready) lat = cyc - t0;
      end
      if (lat < 0) chk_eq("ready_timeout", ready, 1);
   endtask

   task automatic pulse0(input int hi, input int lo);
      raw_pir[0] = 1'b1; step(hi);
      raw_pir[0] = 1'b0; step(lo);
   endtask

   initial begin : stimulus
      int t, t0, rdy, rise, fall, lat, nr, nf;
      bit any_out, prev;

      step(3);
      chk_eq("rst_pir1", pir_sensor_1, 0);
      chk_eq("rst_pir2", pir_sensor_2, 0);
      chk_eq("rst_pir3", pir_sensor_3, 0);
      chk_eq("rst_ready", ready, 0);
`ifdef PIR_EVENT_COUNT_EN
      chk_eq("rst_event_count", event_count, 0);
`endif
      rst_n = 1'b1;

      // Warm-up: outputs stay low despite motion, ready after W edges.
      turn = 1'b1; t0 = cyc + 1; rdy = -1; any_out = 0;
      for (int k = 0; k < 400 && rdy < 0; k++) begin
         raw_pir = ((cyc + 1 - t0) >= 10 && (cyc + 1 - t0) <= 150) ? 3'b111 : 3'b000;
         step(1);
         if (pir_sensor_1 || pir_sensor_2 || pir_sensor_3) any_out = 1;
         if (ready) rdy = cyc;
      end
      chk_eq("warmup_ready_at", rdy - t0, W);
      chk_eq("warmup_outputs", any_out, 0);
      raw_pir = 3'b000; step(5);

      // Qualify and hold latency on channel 0.
      t = cyc + 1; rise = -1; fall = -1; raw_pir[0] = 1'b1;
      for (int k = 0; k < 200 && fall < 0; k++) begin
         if (cyc + 1 - t == 30) raw_pir[0] = 1'b0;
         step(1);
         if (rise < 0 && pir_sensor_1) rise = cyc;
         if (rise >= 0 && fall < 0 && !pir_sensor_1) fall = cyc;
      end
      chk_eq("qual_rise_lat", rise - t, 2 + D);
      chk_eq("hold_fall_lat", fall - t, 82);
`ifdef PIR_EVENT_COUNT_EN
      chk_eq("qual_event_count", event_count, 1);
`endif
      step(5);

      // Glitch rejection on channel 1.
      any_out = 0;
      raw_pir[1] = 1'b1; step(5); raw_pir[1] = 1'b0;
      for (int k = 0; k < 70; k++) begin step(1); if (pir_sensor_2) any_out = 1; end
      chk_eq("glitch_pir2", any_out, 0);
`ifdef PIR_EVENT_COUNT_EN
      chk_eq("glitch_event_count", event_count, 1);
`endif

      // Retrigger on channel 2: exactly one rise and one fall.
      nr = 0; nf = 0; prev = 0;
      for (int k = 0; k < 160; k++) begin
         raw_pir[2] = (k < 20) || (k >= 50 && k < 70);
         step(1);
         if (pir_sensor_3 && !prev) nr++;
         if (!pir_sensor_3 && prev) nf++;
         prev = pir_sensor_3;
      end
      chk_eq("retrig_rises", nr, 1);
      chk_eq("retrig_falls", nf, 1);
`ifdef PIR_EVENT_COUNT_EN
      chk_eq("retrig_event_count", event_count, 2);
`endif

      // Disarm while channel 0 is holding.
      raw_pir[0] = 1'b1; step(20); raw_pir[0] = 1'b0; step(10);
      chk_eq("disarm_pre_pir1", pir_sensor_1, 1);
      turn = 1'b0; step(1);
      chk_eq("disarm_pir1", pir_sensor_1, 0);
      chk_eq("disarm_ready", ready, 0);
`ifdef PIR_EVENT_COUNT_EN
      chk_eq("disarm_event_count", event_count, 0);
`endif
      step(3);
      arm_and_wait(lat);
      chk_eq("rearm_ready_at", lat, W);

      // Random traffic with occasional disarm; the monitor compares every cycle.
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < 3; b++)
               if ($urandom_range(0, 15) == 0) raw_pir[b] = ~raw_pir[b];
            if ($urandom_range(0, 599) == 0) turn = ~turn;
            step(1);
         end
         turn = 1'b1;
      end
      raw_pir = 3'b000;

`ifdef PIR_EVENT_COUNT_EN
      turn = 1'b0; step(2);
      arm_and_wait(lat);
      for (int p = 0; p < 300; p++) pulse0(12, 56);
      chk_eq("sat_event_count", event_count, 255);
      turn = 1'b0; step(2);
      arm_and_wait(lat);
      for (int p = 0; p < 10; p++) pulse0(12, 56);
      chk_eq("pre_simul_event_count", event_count, 10);
      raw_pir = 3'b111; step(12); raw_pir = 3'b000; step(3);
      chk_eq("simul_event_count", event_count, 13);
`endif

      step(5);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
